payload_engine_chain: RTL
=========================

PAYLOAD_ENGINE_CHAIN -- requirements
Module: payload_engine_chain

Interface
REQ-001 The block SHALL have parameter N_STATES, default 24, meaning the number of chained byte-match stages (2..64).
REQ-002 The block SHALL have parameter LOOP_MASK, width N_STATES, default bit 22 set, meaning stages with a self-loop for one-or-more class repeats.
REQ-003 The block SHALL have parameter ANCHORED, default 0, meaning stage 0 may only start on the first enabled byte after sod.
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port sod  input  1  start-of-data reset, synchronous, active-high.
REQ-006 Port en  input  1  byte-valid strobe; the byte is consumed on a cycle with en=1.
REQ-007 Port char_hit  input  N_STATES  bit i is 1 when the current byte is in stage i's character class.
REQ-008 Port state_vec  output  N_STATES  registered stage flags.
REQ-009 Port match  output  1  sticky match flag.
REQ-010 Port match_pulse  output  1  one-cycle strobe on the 0->1 transition of match.
REQ-011 Port match_offset  output  16  byte index of the byte that completed the first match.

Function
REQ-012 On an en=1 cycle, stage i SHALL load char_hit[i] AND (pred_i OR (LOOP_MASK[i] AND state_vec[i])).
REQ-013 Predecessor pred_0 SHALL be 1 when ANCHORED=0, and SHALL be first_byte when ANCHORED=1; pred_i SHALL be state_vec[i-1] for i>0.
REQ-014 On an en=0 cycle, all registers SHALL hold their value.
REQ-015 Flag first_byte SHALL be set by sod and cleared by the first en=1 cycle.
REQ-016 On an en=1 cycle, match SHALL load match OR state_vec[N_STATES-1], so once set it stays set until sod.
REQ-017 Latency: a final byte consumed on cycle t SHALL set state_vec[N_STATES-1] at t+1 and match at t+2, given en=1 at t+1.
REQ-018 match_pulse SHALL be 1 for exactly the cycle in which match first reads 1 after sod, and 0 otherwise.
REQ-019 Counter byte_cnt (16 bit) SHALL increment on each en=1 cycle and SHALL saturate at 0xFFFF without wrapping.
REQ-020 match_offset SHALL capture the byte_cnt value of the byte that set state_vec[N_STATES-1] the first time after sod, and SHALL then hold.
REQ-021 Byte index 0 SHALL be the first enabled byte after sod.
REQ-022 Overlapping and restarting partial matches SHALL all be tracked in parallel (NFA semantics), with no backtracking.

Reset
REQ-023 When sod=1 at a rising clk edge, state_vec, match, match_pulse, match_offset and byte_cnt SHALL clear to 0 and first_byte SHALL be set to 1.
REQ-024 sod SHALL take priority over en; the byte presented with sod=1 SHALL NOT be consumed.
REQ-025 A sod arriving mid-packet or mid-match SHALL discard all partial state with no residual match.
REQ-026 Every output SHALL read 0 in the cycle after sod.

Configuration
REQ-027 When macro PAYLOAD_ENGINE_MATCH_OFFSET_EN is defined, byte_cnt and the match_offset capture SHALL be implemented.
REQ-028 When PAYLOAD_ENGINE_MATCH_OFFSET_EN is not defined, byte_cnt SHALL be absent and match_offset SHALL be tied to 0; all other behaviour is unchanged.

Verification
Scenarios use N_STATES=4, LOOP_MASK=4'b0100, ANCHORED=0 and the offset macro defined, unless stated otherwise.
REQ-029 Bench SHALL cover: sod, then bytes 0..3 with char_hit=0001,0010,0100,1000 and en=1 -> match=1 two cycles after byte 3, match_pulse high for one cycle, match_offset=3.
REQ-030 Bench SHALL cover: hits 0001,0010,0100,0100,0100,1000 -> loop stage holds and match_offset=5; repeat with loop removed (0001,0010,1000) -> no match.
REQ-031 Bench SHALL cover: en=0 gaps inserted between every byte of the REQ-029 stream -> same match result and match_offset=3.
REQ-032 Bench SHALL cover: sod asserted together with en on byte 2 of the REQ-029 stream -> state_vec=0, no match, and the next byte has index 0.
REQ-033 Bench SHALL cover: ANCHORED=1 with the REQ-029 stream preceded by one non-matching byte -> no match; without the prefix -> match.
REQ-034 Bench SHALL cover: 70000 en cycles with no match and then the REQ-029 stream -> match_offset=0xFFFF due to saturation; a build without the macro -> match_offset=0 throughout.

Source files
------------

// File: rtl/payload_engine_chain.sv
// Chained byte-class matcher: N_STATES stages run as an NFA, with a sticky match flag and a first-match byte offset.
// Optional feature macro: PAYLOAD_ENGINE_MATCH_OFFSET_EN (byte counter and match_offset capture; otherwise match_offset reads 0).
module payload_engine_chain #(
  parameter int                  N_STATES  = 24,
  parameter logic [N_STATES-1:0] LOOP_MASK = N_STATES'(64'h1 << 22),
  parameter int                  ANCHORED  = 0
) (
  input  logic                clk,
  input  logic                sod,
  input  logic                en,
  input  logic [N_STATES-1:0] char_hit,
  output logic [N_STATES-1:0] state_vec,
  output logic                match,
  output logic                match_pulse,
  output logic [15:0]         match_offset
);

  // Byte strobe: a byte is consumed on every rising edge with en=1 and sod=0.
  // There is no back-pressure; sod wins over en and its byte is dropped.

  logic [N_STATES-1:0] state_q;
  logic [N_STATES-1:0] state_d;
  logic [N_STATES-1:0] pred;
  logic                first_byte_q;
  logic                match_q;
  logic                pulse_q;

  // Stage 0 may start a new attempt on any byte, or only on the first byte when anchored.
  always_comb begin
    pred    = {state_q[N_STATES-2:0], (ANCHORED != 0) ? first_byte_q : 1'b1};
    state_d = char_hit & (pred | (LOOP_MASK & state_q));
  end

  always_ff @(posedge clk) begin
    if (sod) begin
      state_q      <= '0;
      match_q      <= 1'b0;
      pulse_q      <= 1'b0;
      first_byte_q <= 1'b1;
    end else begin
      // The pulse is a strobe: it drops on the following edge even when en=0.
      pulse_q <= en & ~match_q & state_q[N_STATES-1];
      if (en) begin
        state_q      <= state_d;
        match_q      <= match_q | state_q[N_STATES-1];
        first_byte_q <= 1'b0;
      end
    end
  end

`ifdef PAYLOAD_ENGINE_MATCH_OFFSET_EN
  logic [15:0] byte_cnt;
  logic [15:0] offset_q;
  logic        captured_q;

  // byte_cnt holds the index of the byte being consumed this cycle.
  always_ff @(posedge clk) begin
    if (sod) begin
      byte_cnt   <= '0;
      offset_q   <= '0;
      captured_q <= 1'b0;
    end else if (en) begin
      if (byte_cnt != 16'hFFFF) begin
        byte_cnt <= byte_cnt + 16'd1;
      end
      if (state_d[N_STATES-1] && !captured_q) begin
        offset_q   <= byte_cnt;
        captured_q <= 1'b1;
      end
    end
  end

  assign match_offset = offset_q;
`else
  assign match_offset = '0;
`endif

  assign state_vec   = state_q;
  assign match       = match_q;
  assign match_pulse = pulse_q;

endmodule
